// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner. Each channel has a 2-FF synchroniser, a counter debounce,
// press/release pulses and an optional hold-to-auto-repeat pulse train.

module btn_conditioner_ch #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic clk_148Mhz,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic apasat,
    output logic eliberat,
    output logic repeat_pulse
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    logic          db_term, press_acc, release_acc;

    // Terminal count on a mismatching sample is the exact edge the level flips.
    assign db_term     = (s2 != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign press_acc   = db_term & s2;
    assign release_acc = db_term & ~s2;

    always_ff @(posedge clk_148Mhz or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            level    <= 1'b0;
            db_cnt   <= '0;
            apasat   <= 1'b0;
            eliberat <= 1'b0;
        end else begin
            s1       <= btn_raw;
            s2       <= s1;
            apasat   <= press_acc;
            eliberat <= release_acc;
            if (s2 == level) begin
                db_cnt <= '0;
            end else if (db_term) begin
                level  <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    if (REPEAT_EN) begin : g_rep
        typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
        state_t        state, state_nxt;
        logic [RW-1:0] rcnt, rcnt_nxt;
        logic          rep_nxt;
        logic          hold_term, rpt_term;

        assign hold_term = (rcnt == RW'(HOLD_CYCLES - 1));
        assign rpt_term  = (rcnt == RW'(REPEAT_CYCLES - 1));

        always_ff @(posedge clk_148Mhz or negedge reset_n) begin
            if (!reset_n) begin
                state        <= IDLE;
                rcnt         <= '0;
                repeat_pulse <= 1'b0;
            end else begin
                state        <= state_nxt;
                rcnt         <= rcnt_nxt;
                repeat_pulse <= rep_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (press_acc) state_nxt = HOLD;
                HOLD:    if (release_acc) state_nxt = IDLE;
                         else if (hold_term) state_nxt = RPT;
                RPT:     if (release_acc) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        // Release wins over a coinciding terminal count, so no pulse on the release edge.
        always_comb begin
            rcnt_nxt = '0;
            rep_nxt  = 1'b0;
            case (state)
                HOLD: if (!release_acc) begin
                    if (hold_term) rep_nxt = 1'b1;
                    else           rcnt_nxt = rcnt + RW'(1);
                end
                RPT: if (!release_acc) begin
                    if (rpt_term) rep_nxt = 1'b1;
                    else          rcnt_nxt = rcnt + RW'(1);
                end
                default: ;
            endcase
        end
    end else begin : g_norep
        assign repeat_pulse = 1'b0;
    end
endmodule

module btn_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = {N_BTN{1'b0}},
    parameter bit               REPEAT_EN       = 1'b1,
    parameter int               HOLD_CYCLES     = 1000,
    parameter int               REPEAT_CYCLES   = 250
) (
    input  logic             clk_148Mhz,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_apasat,
    output logic [N_BTN-1:0] btn_eliberat,
    output logic [N_BTN-1:0] btn_repeat
);
    logic [N_BTN-1:0] btn_pol;

    assign btn_pol = btn ^ ACTIVE_LOW_MASK;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_conditioner_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk_148Mhz  (clk_148Mhz),
            .reset_n     (reset_n),
            .btn_raw     (btn_pol[g]),
            .level       (btn_level[g]),
            .apasat      (btn_apasat[g]),
            .eliberat    (btn_eliberat[g]),
            .repeat_pulse(btn_repeat[g])
        );
    end
endmodule
